ccr_cond_eval: RTL and testbench

Buffered condition-evaluation stage directly downstream of the subtractor/ALU stage. Each accepted entry carries a result word `R`, its 4-bit condition code register (CVNZ) and a condition selector. The block evaluates the selected condition against the flags and queues the result, flags and a `taken` bit in a 2-entry FIFO behind a valid/ready handshake. Consumers such as a branch sequencer or compare-and-select logic pop entries from that FIFO.

---
 rtl/ccr_pkg.sv | 32 +++
 rtl/cond_decode.sv | 45 ++++
 rtl/ccr_cond_eval.sv | 82 ++++++++
 tb/tb_ccr_cond_eval.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - shared flag indices, flag masks and condition-code selector enum
package ccr_pkg;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Single source of flag masks for both the subtractor and the condition evaluator
  localparam logic [3:0] CCR_C_MASK = 4'b1000;
  localparam logic [3:0] CCR_V_MASK = 4'b0100;
  localparam logic [3:0] CCR_N_MASK = 4'b0010;
  localparam logic [3:0] CCR_Z_MASK = 4'b0001;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_NV = 4'd1,
    COND_EQ = 4'd2,
    COND_NE = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_CS = 4'd6,
    COND_CC = 4'd7,
    COND_VS = 4'd8,
    COND_VC = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13
  } cond_e;

endpackage

// File: rtl/cond_decode.sv
// rtl/cond_decode.sv - combinational condition evaluator; signed selectors 10-13 only with CCR_SIGNED_EN
module cond_decode
  import ccr_pkg::*;
(
  input  logic [3:0] ccr,
  input  logic [3:0] cond,
  output logic       taken,
  output logic       illegal
);

  logic w_c;
  logic w_v;
  logic w_n;
  logic w_z;

  assign w_c = |(ccr & CCR_C_MASK);
  assign w_v = |(ccr & CCR_V_MASK);
  assign w_n = |(ccr & CCR_N_MASK);
  assign w_z = |(ccr & CCR_Z_MASK);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      COND_EQ: taken = w_z;
      COND_NE: taken = !w_z;
      COND_MI: taken = w_n;
      COND_PL: taken = !w_n;
      COND_CS: taken = w_c;
      COND_CC: taken = !w_c;
      COND_VS: taken = w_v;
      COND_VC: taken = !w_v;
`ifdef CCR_SIGNED_EN
      COND_GE: taken = (w_n == w_v);
      COND_LT: taken = (w_n != w_v);
      COND_GT: taken = !w_z && (w_n == w_v);
      COND_LE: taken = w_z || (w_n != w_v);
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ccr_cond_eval.sv
// rtl/ccr_cond_eval.sv - condition evaluation at push time into a 2-entry valid/ready FIFO (CCR_SIGNED_EN enables signed selectors)
module ccr_cond_eval
  import ccr_pkg::*;
#(
  parameter int op_size = 4,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [op_size-1:0] in_r,
  input  logic [3:0]         in_ccr,
  input  logic [3:0]         in_cond,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [op_size-1:0] out_r,
  output logic [3:0]         out_ccr,
  output logic               out_taken,
  output logic               out_illegal
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [op_size-1:0] r_mem_r     [2];
  logic [3:0]         r_mem_ccr   [2];
  logic               r_mem_taken [2];
  logic               r_mem_ill   [2];
  logic [1:0]         r_count;
  logic               r_wr_ptr;
  logic               r_rd_ptr;

  logic w_push;
  logic w_pop;
  logic w_taken;
  logic w_illegal;

  cond_decode u_cond_decode (
    .ccr     (in_ccr),
    .cond    (in_cond),
    .taken   (w_taken),
    .illegal (w_illegal)
  );

  // Both handshake outputs decode registered occupancy only, so a pop never opens in_ready in the same cycle
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_r[r_wr_ptr]     <= in_r;
      r_mem_ccr[r_wr_ptr]   <= in_ccr;
      r_mem_taken[r_wr_ptr] <= w_taken;
      r_mem_ill[r_wr_ptr]   <= w_illegal;
    end
  end

  // Storage is not reset, so outputs are gated to zero whenever nothing is queued
  assign out_r       = out_valid ? r_mem_r[r_rd_ptr]     : '0;
  assign out_ccr     = out_valid ? r_mem_ccr[r_rd_ptr]   : 4'd0;
  assign out_taken   = out_valid ? r_mem_taken[r_rd_ptr] : 1'b0;
  assign out_illegal = out_valid ? r_mem_ill[r_rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_ccr_cond_eval.sv
// tb/tb_ccr_cond_eval.sv - self-checking bench for ccr_cond_eval with a queue-based reference model
module tb_ccr_cond_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_r = 4'd0;
  logic [3:0] in_ccr = 4'd0;
  logic [3:0] in_cond = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_r;
  logic [3:0] out_ccr;
  logic       out_taken;
  logic       out_illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] r;
    logic [3:0] ccr;
    logic       t;
    logic       il;
  } ent_t;

  ent_t q[$];

  ccr_cond_eval #(.op_size(4), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r        (in_r),
    .in_ccr      (in_ccr),
    .in_cond     (in_cond),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_ccr     (out_ccr),
    .out_taken   (out_taken),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Returns {taken, illegal} from the condition table
  function automatic logic [1:0] exp_eval(input logic [3:0] cond, input logic [3:0] ccr);
    int c, v, n, z, sel;
    c = ccr[3]; v = ccr[2]; n = ccr[1]; z = ccr[0];
    sel = cond;
    if (sel == 0) return 2'b10;
    if (sel == 1) return 2'b00;
    if (sel == 2) return {z == 1, 1'b0};
    if (sel == 3) return {z == 0, 1'b0};
    if (sel == 4) return {n == 1, 1'b0};
    if (sel == 5) return {n == 0, 1'b0};
    if (sel == 6) return {c == 1, 1'b0};
    if (sel == 7) return {c == 0, 1'b0};
    if (sel == 8) return {v == 1, 1'b0};
    if (sel == 9) return {v == 0, 1'b0};
`ifdef CCR_SIGNED_EN
    if (sel == 10) return {n == v, 1'b0};
    if (sel == 11) return {n != v, 1'b0};
    if (sel == 12) return {(z == 0) && (n == v), 1'b0};
    if (sel == 13) return {(z == 1) || (n != v), 1'b0};
`endif
    return 2'b01;
  endfunction

  // Drives one cycle, advances past the edge and updates the model; no checking here
  task automatic cyc(input logic v, input logic [3:0] r, input logic [3:0] ccr,
                     input logic [3:0] cond, input logic ordy);
    logic do_push, do_pop;
    logic [1:0] ev;
    ent_t e;
    in_valid = v; in_r = r; in_ccr = ccr; in_cond = cond; out_ready = ordy;
    do_push = v && (q.size() < 2);
    do_pop  = ordy && (q.size() > 0);
    ev = exp_eval(cond, ccr);
    e.r = r; e.ccr = ccr; e.t = ev[1]; e.il = ev[0];
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal} !== 12'h800) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h want 800", {in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL idle_handshake: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_eq_ne;
    cyc(1, 4'b0000, 4'b0001, 4'd2, 0);
    n_checks++;
    if ({out_valid, out_r, out_taken, out_illegal} !== 7'b1_0000_1_0) begin
      n_errors++;
      $display("FAIL eq_push: got %b want 1000010", {out_valid, out_r, out_taken, out_illegal});
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL eq_pop: out_valid got %b want 0", out_valid);
    end
    cyc(1, 4'b0000, 4'b0001, 4'd3, 0);
    n_checks++;
    if ({out_valid, out_taken, out_illegal} !== 3'b100) begin
      n_errors++;
      $display("FAIL ne_push: got %b want 100", {out_valid, out_taken, out_illegal});
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_full_stall;
    cyc(1, 4'd5, 4'b0010, 4'd4, 0);
    cyc(1, 4'd6, 4'b0010, 4'd5, 0);
    n_checks++;
    if ({in_ready, out_valid, out_r, out_taken} !== 7'b0_1_0101_1) begin
      n_errors++;
      $display("FAIL full_state: got %b want 0101011", {in_ready, out_valid, out_r, out_taken});
    end
    cyc(1, 4'd7, 4'b0000, 4'd0, 0);
    n_checks++;
    if ({in_ready, out_r} !== 5'b0_0101) begin
      n_errors++;
      $display("FAIL stalled_push: got %b want 00101", {in_ready, out_r});
    end
    // Full with a pop in the same cycle: the held push must still be refused
    cyc(1, 4'd7, 4'b0000, 4'd0, 1);
    n_checks++;
    if ({in_ready, out_valid, out_r, out_taken} !== 7'b1_1_0110_0) begin
      n_errors++;
      $display("FAIL full_push_pop: got %b want 1101100", {in_ready, out_valid, out_r, out_taken});
    end
    cyc(1, 4'd7, 4'b0000, 4'd0, 1);
    n_checks++;
    if ({in_ready, out_valid, out_r, out_taken} !== 7'b1_1_0111_1) begin
      n_errors++;
      $display("FAIL third_pop: got %b want 1101111", {in_ready, out_valid, out_r, out_taken});
    end
    cyc(0, 0, 0, 0, 1);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL drain_empty: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_signed_illegal;
    cyc(1, 4'd3, 4'b0110, 4'd10, 0);
    n_checks++;
`ifdef CCR_SIGNED_EN
    if ({out_taken, out_illegal} !== 2'b10) begin
      n_errors++;
      $display("FAIL ge_signed: got %b want 10", {out_taken, out_illegal});
    end
`else
    if ({out_taken, out_illegal} !== 2'b01) begin
      n_errors++;
      $display("FAIL ge_unsigned_build: got %b want 01", {out_taken, out_illegal});
    end
`endif
    cyc(0, 0, 0, 0, 1);
    cyc(1, 4'd9, 4'b1111, 4'd15, 0);
    n_checks++;
    if ({out_valid, out_r, out_ccr, out_taken, out_illegal} !== 11'b1_1001_1111_0_1) begin
      n_errors++;
      $display("FAIL cond15_illegal: got %b want 11001111101", {out_valid, out_r, out_ccr, out_taken, out_illegal});
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back;
    logic [3:0] vals [8];
    for (int i = 0; i < 8; i++) vals[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 9; i++) begin
      cyc(i < 8, (i < 8) ? vals[i] : 4'd0, 4'($urandom_range(0, 15)), 4'd0, 1);
      n_checks++;
      if (i < 8) begin
        if ({out_valid, out_r, out_taken} !== {1'b1, vals[i], 1'b1}) begin
          n_errors++;
          $display("FAIL stream_%0d: got %b want %b", i, {out_valid, out_r, out_taken}, {1'b1, vals[i], 1'b1});
        end
      end else if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL stream_end: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic       v, ordy, hold;
    logic [3:0] r, ccr, cond;
    logic [11:0] exp_vec;
    hold = 1'b0; r = 0; ccr = 0; cond = 0; v = 0;
    for (int i = 0; i < 300; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        r = 4'($urandom_range(0, 15));
        ccr = 4'($urandom_range(0, 15));
        cond = 4'($urandom_range(0, 15));
      end
      ordy = ($urandom_range(0, 2) != 0);
      hold = v && (q.size() >= 2);
      cyc(v, r, ccr, cond, ordy);
      if (q.size() > 0) exp_vec = {q.size() < 2, 1'b1, q[0].r, q[0].ccr, q[0].t, q[0].il};
      else exp_vec = 12'h800;
      n_checks++;
      if ({in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal} !== exp_vec) begin
        n_errors++;
        $display("FAIL random_%0d: got %h want %h", i, {in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal}, exp_vec);
      end
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset;
    cyc(1, 4'd1, 4'b0001, 4'd2, 0);
    cyc(1, 4'd2, 4'b0001, 4'd3, 0);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_errors++;
      $display("FAIL prereset_full: got %b want 01", {in_ready, out_valid});
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal} !== 12'h800) begin
      n_errors++;
      $display("FAIL async_reset: got %h want 800", {in_ready, out_valid, out_r, out_ccr, out_taken, out_illegal});
    end
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 4'd4, 4'b0000, 4'd0, 0);
    n_checks++;
    if ({in_ready, out_valid, out_r, out_taken} !== 7'b1_1_0100_1) begin
      n_errors++;
      $display("FAIL post_reset_push: got %b want 1101001", {in_ready, out_valid, out_r, out_taken});
    end
  endtask

  initial begin
    test_reset();
    test_eq_ne();
    test_full_stall();
    test_signed_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
